// File: rtl/mc_ctrl_seq.sv
// mc_ctrl_seq: multicycle control sequencer for a MIPS-subset datapath.
// Encoded-state FSM plus a saturating per-state cycle counter; outputs decode the registered state.
module mc_ctrl_seq #(
  parameter int MEM_LAT = 2,
  parameter int MD_MAX  = 40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  input  logic       O,
  input  logic       Zero,
  input  logic       DivZero,
  input  logic       md_done,
  output logic [2:0] IorD,
  output logic       MemWR,
  output logic       IRWrite,
  output logic [1:0] RegDst,
  output logic       RegWR,
  output logic       WriteA,
  output logic       WriteB,
  output logic [1:0] AluSrcA,
  output logic [2:0] AluSrcB,
  output logic [2:0] AluOperation,
  output logic       AluOutWrite,
  output logic [2:0] MemToReg,
  output logic [2:0] PCSource,
  output logic       PCWrite,
  output logic       EPCWrite,
  output logic       md_start,
  output logic       md_sel,
  output logic [4:0] state_o
);

  typedef enum logic [4:0] {
    RST    = 5'd0,
    FETCH  = 5'd1,
    DECODE = 5'd2,
    EXR    = 5'd3,
    WBR    = 5'd4,
    EXI    = 5'd5,
    WBI    = 5'd6,
    MADDR  = 5'd7,
    MRD    = 5'd8,
    WBL    = 5'd9,
    MWR    = 5'd10,
    BR     = 5'd11,
    JMP    = 5'd12,
    MDW    = 5'd13,
    EXC    = 5'd14
  } state_t;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_MULT = 6'b011000;
  localparam logic [5:0] FN_DIV  = 6'b011010;

  localparam logic [1:0] CAUSE_OP   = 2'd0;
  localparam logic [1:0] CAUSE_OVF  = 2'd1;
  localparam logic [1:0] CAUSE_DIV0 = 2'd2;
  localparam logic [1:0] CAUSE_MDTO = 2'd3;

  localparam logic [7:0] LAT_LAST = 8'(MEM_LAT);
  localparam logic [7:0] MD_LAST  = 8'(MD_MAX);

  state_t     state;
  logic [7:0] cnt;
  logic [1:0] cause;

  logic is_r, is_add, is_sub, is_and, is_mult, is_div;
  logic is_addi, is_addiu, is_lw, is_sw, is_beq, is_bne, is_j;
  logic first_cyc, last_lat, div_trap;

  assign is_r      = (OpCode == OP_R);
  assign is_add    = is_r && (Funct == FN_ADD);
  assign is_sub    = is_r && (Funct == FN_SUB);
  assign is_and    = is_r && (Funct == FN_AND);
  assign is_mult   = is_r && (Funct == FN_MULT);
  assign is_div    = is_r && (Funct == FN_DIV);
  assign is_addi   = (OpCode == OP_ADDI);
  assign is_addiu  = (OpCode == OP_ADDIU);
  assign is_lw     = (OpCode == OP_LW);
  assign is_sw     = (OpCode == OP_SW);
  assign is_beq    = (OpCode == OP_BEQ);
  assign is_bne    = (OpCode == OP_BNE);
  assign is_j      = (OpCode == OP_J);

  assign first_cyc = (cnt == 8'd0);
  assign last_lat  = (cnt == LAT_LAST);
  // A divide by zero is only trapped on the MDW entry cycle, before md_start would fire.
  assign div_trap  = first_cyc && is_div && DivZero;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RST;
      cnt   <= '0;
      cause <= CAUSE_OP;
    end else begin
      // NOTE: nonblocking only; the cnt <= '0 in a transition branch below is the last write and wins over this increment.
      if (cnt != 8'hFF) cnt <= cnt + 8'd1;
      case (state)
        RST: begin
          state <= FETCH;
          cnt   <= '0;
        end
        FETCH: begin
          if (last_lat) begin
            state <= DECODE;
            cnt   <= '0;
          end
        end
        DECODE: begin
          cnt <= '0;
          if (is_add || is_sub || is_and)  state <= EXR;
          else if (is_mult || is_div)      state <= MDW;
          else if (is_addi || is_addiu)    state <= EXI;
          else if (is_lw || is_sw)         state <= MADDR;
          else if (is_beq || is_bne)       state <= BR;
          else if (is_j)                   state <= JMP;
          else begin
            state <= EXC;
            cause <= CAUSE_OP;
          end
        end
        EXR: begin
          cnt <= '0;
          if (O && (is_add || is_sub)) begin
            state <= EXC;
            cause <= CAUSE_OVF;
          end else begin
            state <= WBR;
          end
        end
        EXI: begin
          cnt <= '0;
          if (O && is_addi) begin
            state <= EXC;
            cause <= CAUSE_OVF;
          end else begin
            state <= WBI;
          end
        end
        MADDR: begin
          cnt   <= '0;
          state <= is_lw ? MRD : MWR;
        end
        MRD: begin
          if (last_lat) begin
            state <= WBL;
            cnt   <= '0;
          end
        end
        MDW: begin
          if (div_trap) begin
            state <= EXC;
            cause <= CAUSE_DIV0;
            cnt   <= '0;
          end else if (md_done) begin
            state <= FETCH;
            cnt   <= '0;
          end else if (cnt == MD_LAST) begin
            state <= EXC;
            cause <= CAUSE_MDTO;
            cnt   <= '0;
          end
        end
        EXC: begin
          if (last_lat) begin
            state <= FETCH;
            cnt   <= '0;
          end
        end
        WBR, WBI, WBL, MWR, BR, JMP: begin
          state <= FETCH;
          cnt   <= '0;
        end
        default: begin
          state <= RST;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
    IorD         = 3'b000;
    MemWR        = 1'b0;
    IRWrite      = 1'b0;
    RegDst       = 2'b00;
    RegWR        = 1'b0;
    WriteA       = 1'b0;
    WriteB       = 1'b0;
    AluSrcA      = 2'b00;
    AluSrcB      = 3'b000;
    AluOperation = 3'b000;
    AluOutWrite  = 1'b0;
    MemToReg     = 3'b000;
    PCSource     = 3'b000;
    PCWrite      = 1'b0;
    EPCWrite     = 1'b0;
    md_start     = 1'b0;
    md_sel       = 1'b0;
    case (state)
      FETCH: begin
        AluSrcB      = 3'b001;
        AluOperation = 3'b001;
        PCSource     = 3'b010;
        IRWrite      = last_lat;
        PCWrite      = last_lat;
      end
      DECODE: begin
        WriteA       = 1'b1;
        WriteB       = 1'b1;
        AluSrcB      = 3'b011;
        AluOperation = 3'b001;
        AluOutWrite  = 1'b1;
      end
      EXR: begin
        AluSrcA      = 2'b01;
        AluOutWrite  = 1'b1;
        if (is_sub)      AluOperation = 3'b010;
        else if (is_and) AluOperation = 3'b011;
        else             AluOperation = 3'b001;
      end
      WBR: begin
        RegDst = 2'b01;
        RegWR  = 1'b1;
      end
      EXI, MADDR: begin
        AluSrcA      = 2'b01;
        AluSrcB      = 3'b010;
        AluOperation = 3'b001;
        AluOutWrite  = 1'b1;
      end
      WBI: RegWR = 1'b1;
      MRD: IorD = 3'b001;
      WBL: begin
        MemToReg = 3'b001;
        RegWR    = 1'b1;
      end
      MWR: begin
        IorD  = 3'b001;
        MemWR = 1'b1;
      end
      BR: begin
        AluSrcA      = 2'b01;
        AluOperation = 3'b010;
        PCSource     = 3'b001;
        PCWrite      = is_beq ? Zero : !Zero;
      end
      JMP: begin
        PCSource = 3'b011;
        PCWrite  = 1'b1;
      end
      MDW: begin
        md_sel   = is_div;
        md_start = first_cyc && !div_trap;
      end
      EXC: begin
        // Vector-table slot per cause; the first cycle saves PC-4 into EPC.
        IorD     = 3'b010 + {1'b0, cause};
        MemToReg = 3'b010;
        if (first_cyc) begin
          EPCWrite     = 1'b1;
          AluSrcB      = 3'b001;
          AluOperation = 3'b010;
        end
        if (last_lat) begin
          PCSource = 3'b100;
          PCWrite  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign state_o = state;

endmodule

// File: tb/tb_mc_ctrl_seq.sv
// Bench for mc_ctrl_seq: an instruction-level model expands each instruction into the
// expected per-cycle output vectors, compared against the DUT every cycle.
module tb_mc_ctrl_seq;

  localparam int LAT_A   = 2;
  localparam int MDMAX_A = 4;
  localparam int LAT_B   = 4;
  localparam int MDMAX_B = 40;
  localparam int N_VEC   = 17;
  localparam int N_RND   = 150;

  localparam logic [4:0] S_FETCH = 5'd1, S_DECODE = 5'd2, S_EXR = 5'd3, S_WBR = 5'd4;
  localparam logic [4:0] S_EXI = 5'd5, S_WBI = 5'd6, S_MADDR = 5'd7, S_MRD = 5'd8;
  localparam logic [4:0] S_WBL = 5'd9, S_MWR = 5'd10, S_BR = 5'd11, S_JMP = 5'd12;
  localparam logic [4:0] S_MDW = 5'd13, S_EXC = 5'd14;

  localparam logic [5:0] ADD = 6'b100000, SUB = 6'b100010, AND_ = 6'b100100;
  localparam logic [5:0] MULT = 6'b011000, DIV = 6'b011010;
  localparam logic [5:0] ADDI = 6'b001000, ADDIU = 6'b001001, LW = 6'b100011;
  localparam logic [5:0] SW = 6'b101011, BEQ = 6'b000100, BNE = 6'b000101, J = 6'b000010;

  typedef struct packed {
    logic [4:0] state;
    logic [2:0] iord;
    logic       memwr;
    logic       irwrite;
    logic [1:0] regdst;
    logic       regwr;
    logic       writea;
    logic       writeb;
    logic [1:0] alusrca;
    logic [2:0] alusrcb;
    logic [2:0] aluop;
    logic       aluoutwrite;
    logic [2:0] memtoreg;
    logic [2:0] pcsource;
    logic       pcwrite;
    logic       epcwrite;
    logic       md_start;
    logic       md_sel;
  } out_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       ov;
    logic       zero;
    logic       dz;
    int         done_at;
  } instr_t;

  typedef struct {
    instr_t     ins;
    int         exp_cycles;
    logic [2:0] exp_iord;
  } vec_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       ov;
    logic       zero;
    logic       dz;
    logic       mdd;
    out_t       exp;
  } step_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b, sel_b, md_noise;
  logic [5:0] op, fn;
  logic       ov, zero, dz, md_done;
  int         n_checks, n_fail;
  step_t      plan[$];
  vec_t       vecs[N_VEC];

  logic [2:0] a_iord, b_iord, a_alusrcb, b_alusrcb, a_aluop, b_aluop;
  logic [2:0] a_memtoreg, b_memtoreg, a_pcsource, b_pcsource;
  logic [1:0] a_regdst, b_regdst, a_alusrca, b_alusrca;
  logic [4:0] a_state, b_state;
  logic a_memwr, b_memwr, a_irwrite, b_irwrite, a_regwr, b_regwr;
  logic a_writea, b_writea, a_writeb, b_writeb, a_aluoutwrite, b_aluoutwrite;
  logic a_pcwrite, b_pcwrite, a_epcwrite, b_epcwrite;
  logic a_md_start, b_md_start, a_md_sel, b_md_sel;
  out_t a_vec, b_vec, act;

  mc_ctrl_seq #(.MEM_LAT(LAT_A), .MD_MAX(MDMAX_A)) u_a (
    .clk(clk), .reset(rst_a), .OpCode(op), .Funct(fn), .O(ov), .Zero(zero),
    .DivZero(dz), .md_done(md_done), .IorD(a_iord), .MemWR(a_memwr),
    .IRWrite(a_irwrite), .RegDst(a_regdst), .RegWR(a_regwr), .WriteA(a_writea),
    .WriteB(a_writeb), .AluSrcA(a_alusrca), .AluSrcB(a_alusrcb),
    .AluOperation(a_aluop), .AluOutWrite(a_aluoutwrite), .MemToReg(a_memtoreg),
    .PCSource(a_pcsource), .PCWrite(a_pcwrite), .EPCWrite(a_epcwrite),
    .md_start(a_md_start), .md_sel(a_md_sel), .state_o(a_state)
  );

  mc_ctrl_seq #(.MEM_LAT(LAT_B), .MD_MAX(MDMAX_B)) u_b (
    .clk(clk), .reset(rst_b), .OpCode(op), .Funct(fn), .O(ov), .Zero(zero),
    .DivZero(dz), .md_done(md_done), .IorD(b_iord), .MemWR(b_memwr),
    .IRWrite(b_irwrite), .RegDst(b_regdst), .RegWR(b_regwr), .WriteA(b_writea),
    .WriteB(b_writeb), .AluSrcA(b_alusrca), .AluSrcB(b_alusrcb),
    .AluOperation(b_aluop), .AluOutWrite(b_aluoutwrite), .MemToReg(b_memtoreg),
    .PCSource(b_pcsource), .PCWrite(b_pcwrite), .EPCWrite(b_epcwrite),
    .md_start(b_md_start), .md_sel(b_md_sel), .state_o(b_state)
  );

  assign a_vec = {a_state, a_iord, a_memwr, a_irwrite, a_regdst, a_regwr, a_writea,
                  a_writeb, a_alusrca, a_alusrcb, a_aluop, a_aluoutwrite, a_memtoreg,
                  a_pcsource, a_pcwrite, a_epcwrite, a_md_start, a_md_sel};
  assign b_vec = {b_state, b_iord, b_memwr, b_irwrite, b_regdst, b_regwr, b_writea,
                  b_writeb, b_alusrca, b_alusrcb, b_aluop, b_aluoutwrite, b_memtoreg,
                  b_pcsource, b_pcwrite, b_epcwrite, b_md_start, b_md_sel};
  assign act = sel_b ? b_vec : a_vec;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  function automatic instr_t mk(input logic [5:0] o, input logic [5:0] f, input logic v,
                                input logic z, input logic d, input int done_at);
    instr_t i;
    i.op = o; i.fn = f; i.ov = v; i.zero = z; i.dz = d; i.done_at = done_at;
    return i;
  endfunction

  function automatic out_t blank(input logic [4:0] st);
    out_t o;
    o = '0;
    o.state = st;
    return o;
  endfunction

  function automatic logic noise();
    return md_noise && ($urandom_range(0, 1) == 1);
  endfunction

  task automatic add_step(input instr_t in, input out_t o, input logic mdd);
    step_t s;
    s.op = in.op; s.fn = in.fn; s.ov = in.ov; s.zero = in.zero; s.dz = in.dz;
    s.mdd = mdd; s.exp = o;
    plan.push_back(s);
  endtask

  task automatic plan_exc(input instr_t in, input int c, input int lat);
    out_t o;
    for (int k = 0; k <= lat; k++) begin
      o = blank(S_EXC);
      o.iord = 3'(2 + c);
      o.memtoreg = 3'b010;
      if (k == 0) begin o.epcwrite = 1'b1; o.alusrcb = 3'b001; o.aluop = 3'b010; end
      if (k == lat) begin o.pcsource = 3'b100; o.pcwrite = 1'b1; end
      add_step(in, o, noise());
    end
  endtask

  // Expands one instruction into its expected cycle-by-cycle outputs, FETCH to last state.
  task automatic plan_instr(input instr_t in, input int lat, input int mdmax);
    out_t o;
    logic r, div;
    for (int k = 0; k <= lat; k++) begin
      o = blank(S_FETCH);
      o.alusrcb = 3'b001; o.aluop = 3'b001; o.pcsource = 3'b010;
      if (k == lat) begin o.irwrite = 1'b1; o.pcwrite = 1'b1; end
      add_step(in, o, noise());
    end
    o = blank(S_DECODE);
    o.writea = 1'b1; o.writeb = 1'b1; o.alusrcb = 3'b011; o.aluop = 3'b001; o.aluoutwrite = 1'b1;
    add_step(in, o, noise());
    r = (in.op == 6'd0);
    if (r && (in.fn == ADD || in.fn == SUB || in.fn == AND_)) begin
      o = blank(S_EXR);
      o.alusrca = 2'b01; o.aluoutwrite = 1'b1;
      o.aluop = (in.fn == SUB) ? 3'b010 : (in.fn == AND_) ? 3'b011 : 3'b001;
      add_step(in, o, noise());
      if (in.ov && in.fn != AND_) plan_exc(in, 1, lat);
      else begin
        o = blank(S_WBR); o.regdst = 2'b01; o.regwr = 1'b1;
        add_step(in, o, noise());
      end
    end else if (r && (in.fn == MULT || in.fn == DIV)) begin
      div = (in.fn == DIV);
      if (div && in.dz) begin
        o = blank(S_MDW); o.md_sel = 1'b1;
        add_step(in, o, in.done_at == 1);
        plan_exc(in, 2, lat);
      end else begin
        for (int c = 1; c <= mdmax + 1; c++) begin
          o = blank(S_MDW); o.md_sel = div; o.md_start = (c == 1);
          add_step(in, o, c == in.done_at);
          if (c == in.done_at) break;
          if (c == mdmax + 1) plan_exc(in, 3, lat);
        end
      end
    end else if (in.op == ADDI || in.op == ADDIU) begin
      o = blank(S_EXI);
      o.alusrca = 2'b01; o.alusrcb = 3'b010; o.aluop = 3'b001; o.aluoutwrite = 1'b1;
      add_step(in, o, noise());
      if (in.op == ADDI && in.ov) plan_exc(in, 1, lat);
      else begin
        o = blank(S_WBI); o.regwr = 1'b1;
        add_step(in, o, noise());
      end
    end else if (in.op == LW || in.op == SW) begin
      o = blank(S_MADDR);
      o.alusrca = 2'b01; o.alusrcb = 3'b010; o.aluop = 3'b001; o.aluoutwrite = 1'b1;
      add_step(in, o, noise());
      if (in.op == LW) begin
        for (int k = 0; k <= lat; k++) begin
          o = blank(S_MRD); o.iord = 3'b001;
          add_step(in, o, noise());
        end
        o = blank(S_WBL); o.memtoreg = 3'b001; o.regwr = 1'b1;
        add_step(in, o, noise());
      end else begin
        o = blank(S_MWR); o.iord = 3'b001; o.memwr = 1'b1;
        add_step(in, o, noise());
      end
    end else if (in.op == BEQ || in.op == BNE) begin
      o = blank(S_BR);
      o.alusrca = 2'b01; o.aluop = 3'b010; o.pcsource = 3'b001;
      o.pcwrite = (in.op == BEQ) ? in.zero : !in.zero;
      add_step(in, o, noise());
    end else if (in.op == J) begin
      o = blank(S_JMP); o.pcsource = 3'b011; o.pcwrite = 1'b1;
      add_step(in, o, noise());
    end else begin
      plan_exc(in, 0, lat);
    end
  endtask

  // Drives the planned steps (up to max_steps) and compares every cycle; also measures
  // the DUT's own cycle count until it returns to FETCH and the IorD it showed in EXC.
  task automatic run_plan(input string tag, input int max_steps, output int cyc,
                          output logic [2:0] exc_iord);
    bit left_fetch, back;
    left_fetch = 0; back = 0; cyc = 0; exc_iord = 3'b000;
    for (int i = 0; i < plan.size() && i < max_steps; i++) begin
      @(posedge clk);
      #1;
      op = plan[i].op; fn = plan[i].fn; ov = plan[i].ov; zero = plan[i].zero;
      dz = plan[i].dz; md_done = plan[i].mdd;
      @(negedge clk);
      check($sformatf("%s[%0d]", tag, i), 64'(act), 64'(plan[i].exp));
      if (!back) begin
        if (act.state == S_FETCH && left_fetch) back = 1;
        else begin
          cyc++;
          if (act.state != S_FETCH) left_fetch = 1;
        end
      end
      if (act.state == S_EXC) exc_iord = act.iord;
    end
    plan.delete();
  endtask

  task automatic reset_mid_a(input string tag, input instr_t in, input int steps);
    int cyc;
    logic [2:0] io;
    plan_instr(in, LAT_A, MDMAX_A);
    run_plan(tag, steps, cyc, io);
    #2 rst_a = 1'b1;
    #1 check({tag, "_async_reset"}, 64'(act), 64'(0));
    @(negedge clk);
    check({tag, "_held_reset"}, 64'(act), 64'(0));
    rst_a = 1'b0;
  endtask

  function automatic bit known_op(input logic [5:0] o);
    return o == 6'd0 || o == ADDI || o == ADDIU || o == LW || o == SW ||
           o == BEQ || o == BNE || o == J;
  endfunction

  task automatic rand_instr(output instr_t in);
    int k;
    k = $urandom_range(0, 13);
    in = mk(6'($urandom), 6'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            $urandom_range(0, 6));
    case (k)
      0:  begin in.op = 6'd0; in.fn = ADD; end
      1:  begin in.op = 6'd0; in.fn = SUB; end
      2:  begin in.op = 6'd0; in.fn = AND_; end
      3:  begin in.op = 6'd0; in.fn = MULT; end
      4:  begin in.op = 6'd0; in.fn = DIV; end
      5:  in.op = ADDI;
      6:  in.op = ADDIU;
      7:  in.op = LW;
      8:  in.op = SW;
      9:  in.op = BEQ;
      10: in.op = BNE;
      11: in.op = J;
      12: while (known_op(in.op)) in.op = 6'($urandom);
      default: begin
        in.op = 6'd0;
        while (in.fn == ADD || in.fn == SUB || in.fn == AND_ || in.fn == MULT || in.fn == DIV)
          in.fn = 6'($urandom);
      end
    endcase
  endtask

  initial begin
    int cyc;
    logic [2:0] io;
    instr_t ins;

    // {instruction, DUT cycles FETCH..last state, IorD seen in EXC} for MEM_LAT=2, MD_MAX=4.
    vecs[0]  = '{mk(6'd0, ADD,  0, 0, 0, 0), 6,  3'd0};
    vecs[1]  = '{mk(6'd0, SUB,  1, 0, 0, 0), 8,  3'd3};
    vecs[2]  = '{mk(6'd0, AND_, 1, 0, 0, 0), 6,  3'd0};
    vecs[3]  = '{mk(6'd0, ADD,  1, 0, 0, 0), 8,  3'd3};
    vecs[4]  = '{mk(6'd0, DIV,  0, 0, 1, 0), 8,  3'd4};
    vecs[5]  = '{mk(6'd0, MULT, 0, 0, 0, 5), 9,  3'd0};
    vecs[6]  = '{mk(6'd0, MULT, 0, 0, 0, 0), 12, 3'd5};
    vecs[7]  = '{mk(6'd0, MULT, 0, 0, 0, 1), 5,  3'd0};
    vecs[8]  = '{mk(6'd0, DIV,  0, 0, 0, 2), 6,  3'd0};
    vecs[9]  = '{mk(ADDI,  6'd0, 1, 0, 0, 0), 8, 3'd3};
    vecs[10] = '{mk(ADDIU, 6'd0, 1, 0, 0, 0), 6, 3'd0};
    vecs[11] = '{mk(LW,    6'd0, 0, 0, 0, 0), 9, 3'd0};
    vecs[12] = '{mk(SW,    6'd0, 0, 0, 0, 0), 6, 3'd0};
    vecs[13] = '{mk(BEQ,   6'd0, 0, 0, 0, 0), 5, 3'd0};
    vecs[14] = '{mk(BNE,   6'd0, 0, 0, 0, 0), 5, 3'd0};
    vecs[15] = '{mk(6'b111111, 6'd0, 0, 0, 0, 0), 7, 3'd2};
    vecs[16] = '{mk(6'd0, 6'd0,  0, 0, 0, 0), 7, 3'd2};

    n_checks = 0; n_fail = 0;
    sel_b = 1'b0; md_noise = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1;
    op = '0; fn = '0; ov = 1'b0; zero = 1'b0; dz = 1'b0; md_done = 1'b1;

    #1 check("reset_outputs_a", 64'(act), 64'(0));
    sel_b = 1'b1;
    #1 check("reset_outputs_b", 64'(act), 64'(0));
    sel_b = 1'b0;
    md_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    #1 check("rst_state_before_edge", 64'(act.state), 64'(0));

    for (int i = 0; i < N_VEC; i++) begin
      plan_instr(vecs[i].ins, LAT_A, MDMAX_A);
      run_plan($sformatf("vec%0d", i), 1000, cyc, io);
      check($sformatf("vec%0d_cycles", i), 64'(cyc), 64'(vecs[i].exp_cycles));
      check($sformatf("vec%0d_exc_iord", i), 64'(io), 64'(vecs[i].exp_iord));
    end

    reset_mid_a("mid_fetch", mk(6'd0, ADD, 0, 0, 0, 0), 2);
    reset_mid_a("mid_mdw",   mk(6'd0, MULT, 0, 0, 0, 0), 6);
    reset_mid_a("mid_exc",   mk(6'd0, SUB, 1, 0, 0, 0), 6);
    plan_instr(mk(J, 6'd0, 0, 0, 0, 0), LAT_A, MDMAX_A);
    run_plan("after_reset_j", 1000, cyc, io);
    check("after_reset_j_cycles", 64'(cyc), 64'(5));

    md_noise = 1'b1;
    for (int n = 0; n < N_RND; n++) begin
      rand_instr(ins);
      plan_instr(ins, LAT_A, MDMAX_A);
      run_plan($sformatf("rnd%0d_op%0h_fn%0h", n, ins.op, ins.fn), 1000, cyc, io);
    end
    md_noise = 1'b0;

    // Second instance: MEM_LAT=4, reset in the middle of an LW memory read.
    @(negedge clk);
    rst_a = 1'b1;
    sel_b = 1'b1;
    rst_b = 1'b0;
    plan_instr(mk(LW, 6'd0, 0, 0, 0, 0), LAT_B, MDMAX_B);
    run_plan("b_lw_part", 9, cyc, io);
    check("b_in_mrd", 64'(act.state), 64'(S_MRD));
    #2 rst_b = 1'b1;
    #1 check("b_mid_mrd_async_reset", 64'(act), 64'(0));
    check("b_mid_mrd_state", 64'(act.state), 64'(0));
    @(negedge clk);
    rst_b = 1'b0;
    #1 check("b_rst_before_edge", 64'(act.state), 64'(0));
    plan_instr(mk(LW, 6'd0, 0, 0, 0, 0), LAT_B, MDMAX_B);
    run_plan("b_lw_full", 1000, cyc, io);
    check("b_lw_cycles", 64'(cyc), 64'(13));
    plan_instr(mk(6'd0, MULT, 0, 0, 0, 5), LAT_B, MDMAX_B);
    run_plan("b_mult_done5", 1000, cyc, io);
    check("b_mult_cycles", 64'(cyc), 64'(11));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_seq.md
MC_CTRL_SEQ -- requirements
Module: mc_ctrl_seq

Interface
REQ-001 SHALL have parameter MEM_LAT, default 2, meaning memory read latency in cycles; legal range 1..15.
REQ-002 SHALL have parameter MD_MAX, default 40, meaning the maximum mult/div wait in cycles before a timeout exception; legal range 2..255.
REQ-003 SHALL have ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high.
- OpCode  in  6  instruction opcode.
- Funct  in  6  R-type funct field.
- O  in  1  ALU overflow flag.
- Zero  in  1  ALU zero flag.
- DivZero  in  1  divisor equals 0.
- md_done  in  1  mult/div unit finished.
- IorD  out  3  memory address select.
- MemWR  out  1  memory write.
- IRWrite  out  1  instruction register load.
- RegDst  out  2  destination register select.
- RegWR  out  1  register file write.
- WriteA, WriteB  out  1 each  A/B latch enables.
- AluSrcA  out  2  ALU A select.
- AluSrcB  out  3  ALU B select.
- AluOperation  out  3  ALU operation.
- AluOutWrite  out  1  ALUOut latch enable.
- MemToReg  out  3  write-back source select.
- PCSource  out  3  next-PC select.
- PCWrite  out  1  PC load.
- EPCWrite  out  1  EPC load.
- md_start  out  1  single-cycle mult/div start pulse.
- md_sel  out  1  0 = mult, 1 = div.
- state_o  out  5  current state code, for debug.

Function
REQ-004 SHALL implement the states RST=0, FETCH=1, DECODE=2, EXR=3, WBR=4, EXI=5, WBI=6, MADDR=7, MRD=8, WBL=9, MWR=10, BR=11, JMP=12, MDW=13, EXC=14; state_o SHALL equal the current state code.
REQ-005 SHALL deassert every output not listed for a state: single-bit outputs 0, buses 0.
REQ-006 SHALL use an internal 8-bit cycle counter, cleared on every state transition.
REQ-007 RST SHALL move to FETCH after one cycle.
REQ-008 FETCH SHALL drive IorD=000, AluSrcA=00, AluSrcB=001, AluOperation=001 and PCSource=010; when counter==MEM_LAT it SHALL additionally assert IRWrite=1 and PCWrite=1, then go to DECODE. FETCH therefore lasts MEM_LAT+1 cycles.
REQ-009 DECODE SHALL last 1 cycle with WriteA=WriteB=1, AluSrcA=00, AluSrcB=011, AluOperation=001 and AluOutWrite=1. It SHALL dispatch as follows:
- OpCode 000000 with Funct 100000/100010/100100 (ADD/SUB/AND) -> EXR.
- Funct 011000/011010 (MULT/DIV) -> MDW.
- OpCode 001000/001001 (ADDI/ADDIU) -> EXI.
- OpCode 100011/101011 (LW/SW) -> MADDR.
- OpCode 000100/000101 (BEQ/BNE) -> BR.
- OpCode 000010 (J) -> JMP.
- Any other opcode/funct -> EXC with cause 0 (op404).
REQ-010 EXR SHALL drive AluSrcA=01 and AluSrcB=000, with AluOperation 001 (ADD), 010 (SUB) or 011 (AND), and AluOutWrite=1. If O=1 and the op is ADD or SUB, it SHALL go to EXC with cause 1 (overflow); otherwise it SHALL go to WBR.
REQ-011 WBR SHALL assert RegDst=01, MemToReg=000 and RegWR=1 for 1 cycle, then go to FETCH.
REQ-012 EXI SHALL drive AluSrcA=01, AluSrcB=010, AluOperation=001 and AluOutWrite=1. For ADDI with O=1 it SHALL go to EXC with cause 1; ADDIU SHALL ignore O. Otherwise it SHALL go to WBI.
REQ-013 WBI SHALL assert RegDst=00, MemToReg=000 and RegWR=1 for 1 cycle, then go to FETCH.
REQ-014 MADDR SHALL drive AluSrcA=01, AluSrcB=010, AluOperation=001 and AluOutWrite=1 for 1 cycle, then go to MRD for LW or MWR for SW.
REQ-015 MRD SHALL drive IorD=001 for MEM_LAT+1 cycles, then go to WBL.
REQ-016 WBL SHALL assert RegDst=00, MemToReg=001 and RegWR=1 for 1 cycle, then go to FETCH.
REQ-017 MWR SHALL assert IorD=001 and MemWR=1 for 1 cycle, then go to FETCH.
REQ-018 BR SHALL drive AluSrcA=01, AluSrcB=000 and AluOperation=010, and SHALL assert PCSource=001 and PCWrite=(Zero for BEQ, !Zero for BNE) for 1 cycle, then go to FETCH.
REQ-019 JMP SHALL assert PCSource=011 and PCWrite=1 for 1 cycle, then go to FETCH.
REQ-020 MDW SHALL handle mult/div as follows:
- On the entry cycle, for DIV with DivZero=1, it SHALL go to EXC with cause 2 and SHALL NOT pulse md_start.
- Otherwise it SHALL pulse md_start=1 on the entry cycle only, with md_sel held for the whole stay.
- It SHALL exit to FETCH on the cycle md_done=1.
- If counter reaches MD_MAX without md_done, it SHALL go to EXC with cause 3.
- md_done asserted on the entry cycle SHALL be honoured.
REQ-021 EXC SHALL assert EPCWrite=1, AluSrcA=00, AluSrcB=001 and AluOperation=010 on its first cycle only, storing PC-4. It SHALL drive IorD=010+cause[1:0] (vector-table address) for MEM_LAT+1 cycles and MemToReg=010. On its last cycle it SHALL assert PCSource=100 and PCWrite=1, then go to FETCH.
REQ-022 Cause SHALL be a 2-bit register loaded on entry to EXC.
REQ-023 The counter SHALL saturate at 255 and SHALL NOT wrap.

Reset
REQ-024 reset=1 SHALL immediately, without waiting for a clock, force state RST, counter 0, cause 0 and every output 0, including mid-FETCH, mid-MDW and mid-EXC.
REQ-025 After reset deasserts, the first rising edge SHALL enter FETCH; no pending md_start or PCWrite SHALL be emitted.

Verification
REQ-026 The bench SHALL cover ADD with MEM_LAT=2 and O=0: FETCH lasts 3 cycles with IRWrite/PCWrite high on the 3rd, then DECODE, EXR, then WBR with RegWR=1; total 6 cycles back to FETCH.
REQ-027 The bench SHALL cover SUB with O=1: EXR -> EXC, EPCWrite pulse of 1 cycle, IorD=011, PCWrite with PCSource=100 on the 3rd EXC cycle.
REQ-028 The bench SHALL cover DIV with DivZero=1 and no md_start: EXC with cause 2 (IorD=100). MULT with md_done at MDW cycle 5: md_start pulses once, then FETCH.
REQ-029 The bench SHALL cover MULT with md_done never asserted and MD_MAX=4: EXC with cause 3 (IorD=101) after 5 MDW cycles.
REQ-030 The bench SHALL cover BEQ with Zero=0 (PCWrite stays 0) and BNE with Zero=0 (PCWrite=1, PCSource=001); and OpCode 111111 -> EXC with cause 0 (IorD=010).
REQ-031 The bench SHALL assert reset mid-MRD with MEM_LAT=4: all outputs 0 before the next edge and state_o=0; after release, FETCH begins and a full LW completes normally.
